// File: rtl/instr_load_ctrl_pkg.sv
// Shared definitions for the instruction BRAM loader/fetch arbiter:
// default widths and the controller state encoding.
package instr_load_ctrl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int BYTE_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_HI = 3'd1,
    S_LOAD_LO = 3'd2,
    S_WRITE   = 3'd3,
    S_RUN     = 3'd4
  } state_t;

endpackage

// File: rtl/instr_load_ctrl_byte_pack.sv
// Assembles two loader bytes (high first) into one instruction word and
// flags when a high byte is still waiting for its low partner.
module instr_byte_pack #(
  parameter int BYTE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                take_hi,
  input  logic                take_lo,
  input  logic [BYTE_W-1:0]   data,
  output logic [2*BYTE_W-1:0] word,
  output logic                half
);

  logic [BYTE_W-1:0] hi_p0;
  logic [BYTE_W-1:0] lo_p0;

  // Stage p0: byte capture (data path, no reset)
  always_ff @(posedge clk) begin
    if (take_hi) hi_p0 <= data;
    if (take_lo) lo_p0 <= data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      half <= 1'b0;
    end else if (take_hi) begin
      half <= 1'b1;
    end else if (take_lo) begin
      half <= 1'b0;
    end
  end

  assign word = {hi_p0, lo_p0};

endmodule

// File: rtl/instr_load_ctrl.sv
// Loads a UART byte stream into the instruction BRAM as 16-bit words, then
// arbitrates CPU fetches against the same BRAM; write and read never overlap.
module instr_load_ctrl
  import instr_load_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_start,
  input  logic              i_byte_valid,
  input  logic [BYTE_W-1:0] i_byte,
  input  logic              i_load_done,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_fetch_valid,
  output logic [DATA_W-1:0] o_fetch_instr,
  output logic              o_fetch_err,
  output logic              o_bram_we,
  output logic [ADDR_W-1:0] o_bram_waddr,
  output logic [DATA_W-1:0] o_bram_wdata,
  output logic              o_bram_re,
  output logic [ADDR_W-1:0] o_bram_raddr,
  input  logic [DATA_W-1:0] i_bram_rdata,
  output logic              o_busy,
  output logic              o_ready,
  output logic [ADDR_W:0]   o_instr_count,
  output logic              o_load_err
);

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W:0]   count;
  logic              load_err;
  logic              take_hi;
  logic              take_lo;
  logic              half;
  logic [DATA_W-1:0] word;
  logic              in_range;
  logic              fetch_hit;
  logic              fetch_miss;
  logic              vld_p1;
  logic              err_p1;

  // Byte strobes lose to start/done in the same cycle; a full BRAM swallows bytes.
  assign take_hi = (state == S_LOAD_HI) && !i_load_start && !i_load_done &&
                   i_byte_valid && (count != FULL);
  assign take_lo = (state == S_LOAD_LO) && !i_load_start && !i_load_done &&
                   i_byte_valid;

  instr_byte_pack #(.BYTE_W(BYTE_W)) u_pack (
    .clk     (i_clk),
    .rst     (i_rst),
    .clear   (i_load_start),
    .take_hi (take_hi),
    .take_lo (take_lo),
    .data    (i_byte),
    .word    (word),
    .half    (half)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      count    <= '0;
      load_err <= 1'b0;
    end else if (i_load_start) begin
      state    <= S_LOAD_HI;
      count    <= '0;
      load_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_IDLE;
        S_LOAD_HI: begin
          if (i_load_done) begin
            state <= S_RUN;
          end else if (i_byte_valid) begin
            if (count == FULL) load_err <= 1'b1;
            else               state    <= S_LOAD_LO;
          end
        end
        S_LOAD_LO: begin
          if (i_load_done) begin
            state <= S_RUN;
            if (half) load_err <= 1'b1;
          end else if (i_byte_valid) begin
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          count <= count + 1'b1;
          state <= i_load_done ? S_RUN : S_LOAD_HI;
        end
        S_RUN:   state <= S_RUN;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: fetch issue, result/error one cycle later with the BRAM data
  assign in_range   = ({1'b0, i_fetch_addr} < count);
  assign fetch_hit  = (state == S_RUN) && i_fetch_req && in_range;
  assign fetch_miss = (state == S_RUN) && i_fetch_req && !in_range;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      vld_p1 <= fetch_hit;
      err_p1 <= fetch_miss;
    end
  end

  assign o_bram_we     = (state == S_WRITE);
  assign o_bram_waddr  = o_bram_we ? count[ADDR_W-1:0] : '0;
  assign o_bram_wdata  = o_bram_we ? word : '0;
  assign o_bram_re     = fetch_hit;
  assign o_bram_raddr  = fetch_hit ? i_fetch_addr : '0;
  assign o_fetch_valid = vld_p1;
  assign o_fetch_instr = vld_p1 ? i_bram_rdata : '0;
  assign o_fetch_err   = err_p1;
  assign o_busy        = (state == S_LOAD_HI) || (state == S_LOAD_LO) || (state == S_WRITE);
  assign o_ready       = (state == S_RUN);
  assign o_instr_count = count;
  assign o_load_err    = load_err;

endmodule
